// File: rtl/morse_pkg.sv
// Shared types and timing constants for the Morse character player.
package morse_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MARK,
        ST_GAP,
        ST_TAIL
    } state_e;

    localparam int DOT_UNITS      = 1;
    localparam int DASH_UNITS     = 3;
    localparam int ELEM_GAP_UNITS = 1;
    localparam int CHAR_GAP_UNITS = 3;
    localparam int ELEMS_PER_CHAR = 5;

endpackage

// File: rtl/morse_unit_timer.sv
// Down-counter for one FSM state: loaded with a 1-unit or 3-unit length,
// counts down to zero and holds there until reloaded.
module morse_unit_timer
    import morse_pkg::*;
#(
    parameter int UNIT_CYCLES = 10_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,       // start a new interval this cycle
    input  logic load_long,  // 1: three units (dash / tail), 0: one unit (dot / gap)
    output logic expired,    // current cycle is the last one of the interval
    output logic near_exp    // next cycle is the last one of the interval
);

    localparam int CNT_W = $clog2(DASH_UNITS * UNIT_CYCLES);
    localparam logic [CNT_W-1:0] LOAD_SHORT = CNT_W'(DOT_UNITS * UNIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOAD_LONG  = CNT_W'(DASH_UNITS * UNIT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next count: reload on request, otherwise decrement and saturate at zero
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_long ? LOAD_LONG : LOAD_SHORT;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign expired  = (cnt_q == '0);
    assign near_exp = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/morse_player.sv
// Plays one five-element Morse character: marks of 1 or 3 units separated
// by 1-unit gaps, followed by a 3-unit tail. Outputs are registered and
// aligned with the state register.
module morse_player
    import morse_pkg::*;
#(
    parameter int UNIT_CYCLES = 10_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [4:0] morse_cord,
    output logic       busy,
    output logic       tone_out,
    output logic       done
);

    state_e     state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [4:0] shreg_q, shreg_d;
    logic       tone_q, tone_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    logic tmr_load, tmr_long, tmr_exp, tmr_near;

    morse_unit_timer #(
        .UNIT_CYCLES(UNIT_CYCLES)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (tmr_load),
        .load_long (tmr_long),
        .expired   (tmr_exp),
        .near_exp  (tmr_near)
    );

    // State, element bookkeeping and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            shreg_q <= '0;
            tone_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            tone_q  <= tone_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next state; the timer is reloaded on every state entry. shreg_q[4]
    // is always the element being played, so the next one is shreg_q[3].
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        shreg_d  = shreg_q;
        tmr_load = 1'b0;
        tmr_long = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_MARK;
                    idx_d    = '0;
                    shreg_d  = morse_cord;
                    tmr_load = 1'b1;
                    tmr_long = morse_cord[4];
                end
            end
            ST_MARK: begin
                if (tmr_exp) begin
                    tmr_load = 1'b1;
                    if (idx_q < 3'(ELEMS_PER_CHAR - 1)) begin
                        state_d  = ST_GAP;
                        tmr_long = (ELEM_GAP_UNITS == DASH_UNITS);
                    end else begin
                        state_d  = ST_TAIL;
                        tmr_long = (CHAR_GAP_UNITS == DASH_UNITS);
                    end
                end
            end
            ST_GAP: begin
                if (tmr_exp) begin
                    state_d  = ST_MARK;
                    idx_d    = idx_q + 1'b1;
                    shreg_d  = {shreg_q[3:0], 1'b0};
                    tmr_load = 1'b1;
                    tmr_long = shreg_q[3];
                end
            end
            ST_TAIL: begin
                if (tmr_exp) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Registered outputs track the next state; done is raised so that it
    // lands on the final TAIL cycle.
    always_comb begin
        tone_d = (state_d == ST_MARK);
        busy_d = (state_d != ST_IDLE);
        done_d = (state_q == ST_TAIL) && tmr_near;
    end

    assign tone_out = tone_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_morse_player.sv
// Directed bench for morse_player with UNIT_CYCLES=4.
module tb_morse_player;

    localparam int U = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [4:0] morse_cord = '0;
    logic       busy, tone_out, done;

    int n_chk = 0;
    int n_err = 0;

    morse_player #(.UNIT_CYCLES(U)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .morse_cord (morse_cord),
        .busy       (busy),
        .tone_out   (tone_out),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Expected tone at cycle k after the capture edge
    function automatic int exp_tone(input logic [4:0] c, input int k);
        int t, m;
        t = 0;
        for (int i = 4; i >= 0; i--) begin
            m = c[i] ? 3 * U : U;
            if (k < t + m) return 1;
            t += m;
            if (i > 0) begin
                if (k < t + U) return 0;
                t += U;
            end
        end
        return 0;
    endfunction

    function automatic int exp_len(input logic [4:0] c);
        int n;
        n = 7 * U;
        for (int i = 0; i < 5; i++) n += c[i] ? 3 * U : U;
        return n;
    endfunction

    // Start one character, optionally poke inputs at cycle poke_k, and
    // check the whole waveform until busy drops.
    task automatic play(input string tag, input logic [4:0] cord, input int poke_k,
                        input logic poke_start, input logic [4:0] poke_cord);
        int len, k, dones, done_at;
        len = exp_len(cord);
        @(negedge clk); start = 1'b1; morse_cord = cord;
        @(negedge clk); start = 1'b0;
        k = 0; dones = 0; done_at = -1;
        while (busy && k < 200) begin
            check({tag, "_tone"}, int'(tone_out), exp_tone(cord, k));
            if (done) begin dones++; done_at = k; end
            if (k == poke_k) begin start = poke_start; morse_cord = poke_cord; end
            else if (k == poke_k + 1) start = 1'b0;
            @(negedge clk); k++;
        end
        check({tag, "_busy_len"}, k, len);
        check({tag, "_done_cnt"}, dones, 1);
        check({tag, "_done_at"}, done_at, len - 1);
        check({tag, "_idle_tone"}, int'(tone_out), 0);
        check({tag, "_idle_done"}, int'(done), 0);
    endtask

    initial begin
        int len, dones;
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_tone", int'(tone_out), 0);
        check("rst_done", int'(done), 0);
        rst_n = 1'b1;
        @(negedge clk);

        play("digit1", 5'b01111, -5, 1'b0, 5'b00000);
        play("digit5", 5'b00000, -5, 1'b0, 5'b00000);
        play("busy_start", 5'b11111, 10, 1'b1, 5'b00000);
        play("cord_change", 5'b10000, 0, 1'b0, 5'b01111);

        // Reset during the second mark (cycles 8..11 for 5'b00000)
        @(negedge clk); start = 1'b1; morse_cord = 5'b00000;
        @(negedge clk); start = 1'b0;
        repeat (9) @(negedge clk);
        check("pre_rst_tone", int'(tone_out), 1);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_tone", int'(tone_out), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_done", int'(done), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_done", int'(done), 0);
        play("after_rst", 5'b00011, -5, 1'b0, 5'b00000);

        // Back-to-back with start held high
        len = exp_len(5'b11000);
        dones = 0;
        @(negedge clk); start = 1'b1; morse_cord = 5'b11000;
        @(negedge clk);
        for (int k = 0; k <= 2 * len + 2; k++) begin
            if (k < len) begin
                check("b2b_busy1", int'(busy), 1);
                check("b2b_tone1", int'(tone_out), exp_tone(5'b11000, k));
            end else if (k == len) begin
                check("b2b_idle_gap", int'(busy), 0);
            end else if (k <= 2 * len) begin
                check("b2b_busy2", int'(busy), 1);
                check("b2b_tone2", int'(tone_out), exp_tone(5'b11000, k - len - 1));
            end else begin
                check("b2b_end_busy", int'(busy), 0);
            end
            check("b2b_done", int'(done), (k == len - 1 || k == 2 * len) ? 1 : 0);
            if (done) dones++;
            if (k == 2 * len) start = 1'b0;
            @(negedge clk);
        end
        check("b2b_done_cnt", dones, 2);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
